// File: rtl/maquina_maluca_pkg.sv
// Shared definitions for the coffee-machine sequencing controller:
// state code width, the recipe state codes and the reset state.
package maquina_maluca_pkg;

    localparam int STATE_W = 4;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE                = 4'd1;
    localparam state_t ST_LIGAR_MAQUINA       = 4'd2;
    localparam state_t ST_VERIFICAR_AGUA      = 4'd3;
    localparam state_t ST_ENCHER_RESERVATORIO = 4'd4;
    localparam state_t ST_MOER_CAFE           = 4'd5;
    localparam state_t ST_COLOCAR_NO_FILTRO   = 4'd6;
    localparam state_t ST_PASSAR_AGITADOR     = 4'd7;
    localparam state_t ST_TAMPEAR             = 4'd8;
    localparam state_t ST_REALIZAR_EXTRACAO   = 4'd9;

    localparam state_t ST_RESET = ST_IDLE;

endpackage

// File: rtl/maquina_maluca_fsm.sv
// Moore FSM that walks the brewing recipe once per start request,
// refilling the reservoir when the water flag is clear.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous reset, active HIGH despite its name
//   start - brew request, only looked at while idle
//   state - current state code, straight from the state register
module maquina_maluca_fsm
    import maquina_maluca_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [STATE_W-1:0] state
);

    state_t state_q;
    state_t state_d;
    logic   agua_ok_q;
    logic   agua_ok_d;

    // State and water-flag registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= ST_RESET;
            agua_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            agua_ok_q <= agua_ok_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        agua_ok_d = agua_ok_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LIGAR_MAQUINA;
                end
            end
            ST_LIGAR_MAQUINA: begin
                state_d = ST_VERIFICAR_AGUA;
            end
            ST_VERIFICAR_AGUA: begin
                if (agua_ok_q) begin
                    state_d = ST_MOER_CAFE;
                end else begin
                    state_d = ST_ENCHER_RESERVATORIO;
                end
            end
            ST_ENCHER_RESERVATORIO: begin
                state_d   = ST_VERIFICAR_AGUA;
                agua_ok_d = 1'b1;
            end
            ST_MOER_CAFE: begin
                state_d = ST_COLOCAR_NO_FILTRO;
            end
            ST_COLOCAR_NO_FILTRO: begin
                state_d = ST_PASSAR_AGITADOR;
            end
            ST_PASSAR_AGITADOR: begin
                state_d = ST_TAMPEAR;
            end
            ST_TAMPEAR: begin
                state_d = ST_REALIZAR_EXTRACAO;
            end
            ST_REALIZAR_EXTRACAO: begin
                // The brew consumes the water, so the next one refills.
                state_d   = ST_IDLE;
                agua_ok_d = 1'b0;
            end
            default: begin
                // Unused codes recover to idle; the flag is left as is.
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: the state code is exported unchanged.
    always_comb begin
        state = state_q;
    end

endmodule

// File: tb/tb_maquina_maluca_fsm.sv
// Self-checking bench for maquina_maluca_fsm: directed recipe checks
// plus randomized start/reset traffic against a queue-based model.
module tb_maquina_maluca_fsm;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_state;
    bit m_agua;
    int m_q[$];

    maquina_maluca_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .state (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a brew is a list of states built when the
    // request is accepted, then consumed one per clock.
    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            m_q.delete();
            exp_state = 1;
            m_agua    = 1'b0;
        end else if (exp_state == 1) begin
            if (start) begin
                exp_state = 2;
                m_q.delete();
                m_q.push_back(3);
                if (!m_agua) begin
                    m_q.push_back(4);
                    m_q.push_back(3);
                end
                m_q.push_back(5);
                m_q.push_back(6);
                m_q.push_back(7);
                m_q.push_back(8);
                m_q.push_back(9);
            end
        end else if (m_q.size() > 0) begin
            exp_state = m_q.pop_front();
            if (exp_state == 4) m_agua = 1'b1;
        end else begin
            exp_state = 1;
            m_agua    = 1'b0;
        end
    end

    always @(negedge clk) begin
        check("state_vs_model", int'(state), exp_state);
    end

    int brew_seq[10] = '{2, 3, 4, 3, 5, 6, 7, 8, 9, 1};

    task automatic pulse_and_check_brew(input string name);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check(name, int'(state), brew_seq[0]);
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            check(name, int'(state), brew_seq[i]);
        end
        @(negedge clk);
        check({name, "_stay_idle"}, int'(state), 1);
    endtask

    task automatic wait_for_state(input int code, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (int'(state) == code) found = 1'b1;
        end
        if (!found) check(name, int'(state), code);
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        #3;
        check("reset_before_edge", int'(state), 1);

        // start held high while reset is asserted
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_hold_start", int'(state), 1);
        rst_n = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("idle_after_release", int'(state), 1);

        pulse_and_check_brew("brew1");
        pulse_and_check_brew("brew2");

        // start pulsed while in COLOCAR_NO_FILTRO
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_for_state(6, "wait_state6");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ignored_start_s7", int'(state), 7);
        repeat (3) @(negedge clk);
        check("ignored_start_idle", int'(state), 1);
        repeat (3) @(negedge clk);
        check("ignored_start_stay", int'(state), 1);

        // continuous start: one idle cycle between brews
        start = 1'b1;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check("continuous", int'(state), brew_seq[i]);
            end
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("continuous_end_idle", int'(state), 1);

        // reset mid-operation in PASSAR_AGITADOR
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_for_state(7, "wait_state7");
        #2;
        rst_n = 1'b1;
        #1;
        check("async_reset_mid", int'(state), 1);
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("after_reset_s2", int'(state), 2);
        @(negedge clk);
        check("after_reset_s3", int'(state), 3);
        @(negedge clk);
        check("after_reset_refill", int'(state), 4);
        repeat (10) @(negedge clk);

        // randomized traffic, model-checked every cycle
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            if (rst_n) begin
                rst_n = 1'b0;
            end else if ($urandom_range(0, 59) == 0) begin
                #($urandom_range(1, 4));
                rst_n = 1'b1;
                #1;
                check("rand_async_reset", int'(state), 1);
            end
        end
        rst_n = 1'b0;
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
